// File: rtl/rr_mux_arbiter.sv
// Round-robin owner arbiter for a shared bus mux: registered one-hot grant plus
// binary select, ownership held until done, request drop, or hold limit.
module rr_mux_arbiter #(
    parameter int NREQ    = 4,
    parameter int SELW    = 2,
    parameter int MAXHOLD = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] done,
    output logic [NREQ-1:0] grant,
    output logic [SELW-1:0] sel,
    output logic            busy,
    output logic            timeout,
    output logic            dbg_own,
    output logic [SELW-1:0] dbg_ptr,
    output logic [(MAXHOLD > 1 ? $clog2(MAXHOLD) : 1)-1:0] dbg_cnt
);

    localparam int CNTW = (MAXHOLD > 1) ? $clog2(MAXHOLD) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(MAXHOLD - 1);
    localparam logic [SELW-1:0] LAST_IDX = SELW'(NREQ - 1);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    // Handshake: req[i] is a level held until the requester has been served;
    // done[i] is a one-cycle strobe and only the current owner's bit matters.

    state_t          state_q, state_d;
    logic [SELW-1:0] ptr_q, ptr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [SELW-1:0] sel_q, sel_d;
    logic            busy_q, busy_d;
    logic            timeout_q, timeout_d;

    logic [SELW:0]   pick;
    logic [SELW-1:0] search_start;
    logic [SELW-1:0] next_after_owner;
    logic            rel_done, rel_drop, rel_limit;

    // Returns {found, index}: first set bit of r scanning start, start+1, ... mod NREQ.
    function automatic logic [SELW:0] find_from(input logic [NREQ-1:0] r,
                                                input logic [SELW-1:0] start);
        logic [SELW:0]   res;
        logic [SELW-1:0] ix;
        int              idx;
        res = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = int'(start) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            ix = SELW'(idx);
            if (r[ix]) res = {1'b1, ix};
        end
        return res;
    endfunction

    assign next_after_owner = (sel_q == LAST_IDX) ? '0 : sel_q + SELW'(1);
    assign rel_done  = done[sel_q];
    assign rel_drop  = ~req[sel_q];
    assign rel_limit = (cnt_q == CNT_LAST);
    assign search_start = (state_q == IDLE) ? ptr_q : next_after_owner;
    assign pick = find_from(req, search_start);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                grant_d = '0;
                sel_d   = '0;
                busy_d  = 1'b0;
                cnt_d   = '0;
                if (pick[SELW]) begin
                    grant_d = NREQ'(1) << pick[SELW-1:0];
                    sel_d   = pick[SELW-1:0];
                    busy_d  = 1'b1;
                    state_d = OWN;
                end
            end
            OWN: begin
                if (rel_done || rel_drop || rel_limit) begin
                    ptr_d     = next_after_owner;
                    cnt_d     = '0;
                    // Forced release only when the owner still wanted the bus.
                    timeout_d = rel_limit && !rel_done && !rel_drop;
                    if (pick[SELW]) begin
                        grant_d = NREQ'(1) << pick[SELW-1:0];
                        sel_d   = pick[SELW-1:0];
                        busy_d  = 1'b1;
                    end else begin
                        grant_d = '0;
                        sel_d   = '0;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                sel_d   = '0;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            grant_q   <= '0;
            sel_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant   = grant_q;
    assign sel     = sel_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;
    assign dbg_own = (state_q == OWN);
    assign dbg_ptr = ptr_q;
    assign dbg_cnt = cnt_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboarded bench for rr_mux_arbiter: a queue-free ownership model predicts
// grant/sel/busy/timeout/ptr each cycle; a negedge monitor pops and compares.
module tb_rr_mux_arbiter;

    localparam int NREQ    = 4;
    localparam int SELW    = 2;
    localparam int MAXHOLD = 15;
    localparam int CNTW    = 4;
    localparam int W       = NREQ + SELW + 2 + SELW;

    logic            clk;
    logic            rst_n;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] done;
    logic [NREQ-1:0] grant;
    logic [SELW-1:0] sel;
    logic            busy;
    logic            timeout;
    logic            dbg_own;
    logic [SELW-1:0] dbg_ptr;
    logic [CNTW-1:0] dbg_cnt;

    logic [W-1:0] exp_q[$];
    int n_cmp;
    int n_bad;

    rr_mux_arbiter #(.NREQ(NREQ), .SELW(SELW), .MAXHOLD(MAXHOLD)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .grant(grant), .sel(sel), .busy(busy), .timeout(timeout),
        .dbg_own(dbg_own), .dbg_ptr(dbg_ptr), .dbg_cnt(dbg_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: who owns the bus, how long they have held it, rotation start
    int m_owner = -1;
    int m_held  = 0;
    int m_ptr   = 0;

    function automatic int first_from(input logic [NREQ-1:0] r, input int start);
        for (int i = 0; i < NREQ; i++) begin
            int j;
            j = (start + i) % NREQ;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        logic [NREQ-1:0] eg;
        logic [SELW-1:0] es;
        logic            et;
        et = 1'b0;
        if (!rst_n) begin
            m_owner = -1;
            m_held  = 0;
            m_ptr   = 0;
        end else if (m_owner < 0) begin
            m_owner = first_from(req, m_ptr);
            m_held  = 0;
        end else begin
            bool_release : begin
                bit by_done, by_drop, by_limit;
                by_done  = done[m_owner];
                by_drop  = !req[m_owner];
                by_limit = (m_held + 1 >= MAXHOLD);
                if (by_done || by_drop || by_limit) begin
                    et      = by_limit && !by_done && !by_drop;
                    m_ptr   = (m_owner + 1) % NREQ;
                    m_owner = first_from(req, m_ptr);
                    m_held  = 0;
                end else begin
                    m_held = m_held + 1;
                end
            end
        end
        eg = (m_owner < 0) ? '0 : NREQ'(1) << m_owner;
        es = (m_owner < 0) ? '0 : SELW'(m_owner);
        exp_q.push_back({eg, es, (m_owner >= 0), et, SELW'(m_ptr)});
    end

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [W-1:0] e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {grant, sel, busy, timeout, dbg_ptr};
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL outputs t=%0t: got grant=%b sel=%0d busy=%b timeout=%b ptr=%0d, need grant=%b sel=%0d busy=%b timeout=%b ptr=%0d",
                         $time, a[W-1 -: NREQ], a[SELW+1+SELW -: SELW], a[SELW+1], a[SELW], a[SELW-1:0],
                         e[W-1 -: NREQ], e[SELW+1+SELW -: SELW], e[SELW+1], e[SELW], e[SELW-1:0]);
            end
        end
    end

    // driver tasks
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic [NREQ-1:0] r, input logic [NREQ-1:0] d);
        req  = r;
        done = d;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        drive('0, '0);
        cyc(n);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [NREQ-1:0] rq;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        req   = '0;
        done  = '0;
        cyc(2);
        rst_n = 1'b1;

        // single requester, done with req dropped
        drive(4'b0100, '0);   cyc(3);
        drive(4'b0000, 4'b0100); cyc(1);
        drive('0, '0);        cyc(3);

        // all requesting, each owner done two cycles after its grant
        do_reset(1);
        drive(4'b1111, '0); cyc(1);
        for (int k = 0; k < 5; k++) begin
            cyc(1);
            drive(4'b1111, 4'b1111); cyc(1);
            drive(4'b1111, '0);
        end
        drive('0, '0); cyc(3);

        // two requesters, never done: hold limit forces alternation
        do_reset(1);
        drive(4'b0011, '0); cyc(3 * MAXHOLD + 4);
        drive('0, '0); cyc(2);

        // non-owner done ignored, then owner drops req
        do_reset(1);
        drive(4'b0010, '0); cyc(2);
        drive(4'b1010, 4'b1000); cyc(1);
        drive(4'b1010, '0); cyc(3);
        drive(4'b1000, '0); cyc(3);
        drive('0, '0); cyc(2);

        // sole requester re-granted after done
        drive(4'b0001, '0); cyc(3);
        drive(4'b0001, 4'b0001); cyc(1);
        drive(4'b0001, '0); cyc(3);
        drive('0, '0); cyc(2);

        // reset in the middle of an ownership
        do_reset(1);
        drive(4'b0100, '0); cyc(2);
        drive(4'b1111, '0); cyc(7);
        rst_n = 1'b0; cyc(1);
        rst_n = 1'b1; cyc(4);

        // randomized traffic with sticky requests, sparse done and rare resets
        rq = '0;
        for (int k = 0; k < 2500; k++) begin
            logic [NREQ-1:0] dn;
            for (int b = 0; b < NREQ; b++)
                if ($urandom_range(0, 7) == 0) rq[b] = ~rq[b];
            dn = '0;
            for (int b = 0; b < NREQ; b++)
                dn[b] = ($urandom_range(0, 9) == 0);
            rst_n = ($urandom_range(0, 299) != 0);
            drive(rq, dn);
            cyc(1);
        end
        rst_n = 1'b1;
        drive('0, '0);
        cyc(3);

        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending, need 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares one wide mux (2–4 sources) feeding a common datapath bus between NREQ requesters.
- Produces a one-hot grant and the binary mux select that steers the granted requester's operand onto the bus.
- Holds ownership until the owner signals done, drops its request, or exceeds a hold limit.
- Sits between the requesting pipeline stages and the shared bus mux.

Parameters:
- NREQ, 4, number of requesters (2..4).
- SELW, 2, select width; must satisfy 2**SELW >= NREQ.
- MAXHOLD, 15, maximum consecutive cycles one owner may hold the bus (1..255).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset (sampled on rising clk).
- req  input  NREQ  request per requester; level, held until granted and served.
- done  input  NREQ  per-requester end-of-transfer strobe; only done[owner] is honoured.
- grant  output  NREQ  one-hot grant, registered; all-zero when idle.
- sel  output  SELW  registered binary index of owner, drives the mux select; 0 when idle.
- busy  output  1  registered; 1 while any grant is asserted.
- timeout  output  1  registered one-cycle pulse when an owner is forcibly released at MAXHOLD.

Behaviour:
- Reset (rst_n=0 at clk edge): grant=0, sel=0, busy=0, timeout=0, rr pointer ptr=0, hold counter cnt=0, state=IDLE. Reset overrides every other event, including mid-grant; no done or timeout is emitted for the aborted owner.
- States: IDLE, OWN.
- IDLE:
  - If req != 0, winner = first set bit searching ptr, ptr+1, ... mod NREQ.
  - Next cycle: grant=onehot(winner), sel=winner, busy=1, cnt=0, state=OWN.
  - Latency: req high in cycle N -> grant visible in cycle N+1.
  - If req==0, outputs stay 0.
- OWN (owner = sel):
  - Release when any of: done[owner]=1; req[owner]=0; cnt==MAXHOLD-1.
  - Otherwise cnt increments by 1 and grant/sel hold.
  - done/req on non-owner bits never affect the grant.
- On release:
  - ptr <= owner+1 mod NREQ.
  - New winner is chosen the same cycle by searching from owner+1, wrapping, with owner checked last. The owner is re-granted only if it is the sole requester and its req is still high.
  - If a winner exists, the next cycle carries the new grant/sel, cnt=0, state stays OWN: back-to-back handoff with no idle bubble.
  - If no winner, the next cycle has grant=0, sel=0, busy=0, state=IDLE.
- Timeout:
  - Release by the cnt rule while done[owner]=0 and req[owner]=1 asserts timeout=1 for exactly the cycle in which the new grant (or idle) appears.
  - If done[owner] or a dropped req coincides with cnt==MAXHOLD-1, it is a normal release with timeout=0.
- Invariants:
  - grant is always zero or one-hot.
  - sel == index(grant) whenever busy=1.
  - busy == |grant.
  - A requester holding req continuously is granted within (NREQ-1)*MAXHOLD+NREQ cycles.
- cnt width is ceil(log2(MAXHOLD)); it never exceeds MAXHOLD-1 and never wraps.
- Bits of req/done at index >= NREQ do not exist. sel values >= NREQ are never produced.

Test Plan:
- Reset, then req=4'b0100 at cycle 1 -> cycle 2: grant=0100, sel=2, busy=1; done[2] pulse at cycle 4 with req dropped -> cycle 5: grant=0, busy=0, ptr=3.
- From reset, req=4'b1111 held, each owner pulses done 2 cycles after its grant -> grant order 0,1,2,3,0 with sel 0,1,2,3,0, no idle cycle between owners, timeout never 1.
- MAXHOLD=15, req=4'b0011 held, done never asserted -> owner 0 for 15 cycles, then timeout=1 with grant=0010, sel=1 in the same cycle; owner 1 likewise -> returns to owner 0.
- Owner 1 granted while done[3] pulses and req[3]=1 -> grant stays 0010; later req[1] falls -> next cycle grant=1000, sel=3, timeout=0.
- req=4'b0001 only, done[0] pulses with req[0] still high -> owner 0 re-granted next cycle, cnt restarts at 0, busy stays 1.
- Owner 2 granted, cnt=7, rst_n=0 for one edge with req=1111 -> next cycle all outputs 0 and ptr=0; with rst_n=1 again, grant=0001 the following cycle.
